// File: rtl/monster_pkg.sv
// Shared types and constants for the monster-jump game blocks.
// Holds the game state encoding, LFSR constants and the scroll-speed helper.
package monster_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_e;

    // Taps 8,6,5,4 of a maximal-length 8-bit Fibonacci LFSR.
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    localparam int         DISP_W       = 8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

    // Step period shrinks by one octave every 16 points, at most 8x, never below 2.
    function automatic int speed_period(input int base, input logic [7:0] score);
        int sh;
        int p;
        sh = (score[7:4] > 4'd3) ? 3 : int'(score[7:4]);
        p  = base >> sh;
        return (p < 2) ? 2 : p;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (shift left, feedback into bit 0) with load-on-reset seed.
// Shared by the barrier spawner and any later pseudo-random spawners.
module lfsr8
    import monster_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] r_q;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= seed;
        end else if (en) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/barrier_sched.sv
// Barrier scroll/spawn scheduler, collision detect and score keeper for the 8x8 display.
// Optional build macro SPEEDUP_EN shortens the scroll period as the score grows.
module barrier_sched
    import monster_pkg::*;
#(
    parameter int         STEP_DIV    = 25000,
    parameter int         MIN_GAP     = 2,
    parameter int         MONSTER_COL = 6,
    parameter logic [7:0] LFSR_SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              airborne,
    output logic [DISP_W-1:0] barrier,
    output logic              running,
    output logic              game_over,
    output logic [7:0]        score,
    output logic              step
);

    localparam int         DIV_W    = $clog2(STEP_DIV + 1);
    localparam logic [2:0] GAP_INIT = 3'(MIN_GAP);

    state_e            r_state;
    logic [DISP_W-1:0] r_barrier;
    logic [7:0]        r_score;
    logic [DIV_W-1:0]  r_div;
    logic [2:0]        r_gap;
    logic              r_running;
    logic              r_game_over;

    logic [7:0]        w_lfsr;
    logic              w_step;
    logic              w_hit;
    logic              w_spawn;
    logic              w_lfsr_en;
    logic              w_enter_run;
    logic [7:0]        w_score_next;
    logic [DIV_W-1:0]  w_div_last;

`ifdef SPEEDUP_EN
    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(STEP_DIV);

    logic [DIV_W-1:0] r_period;

    // Period is latched at each step from the post-step score, so a speedup
    // takes effect from the very next scroll interval.
    always_ff @(posedge clk) begin
        if (rst || w_enter_run) begin
            r_period <= DIV_FULL;
        end else if (w_step && !w_hit) begin
            r_period <= DIV_W'(speed_period(STEP_DIV, w_score_next));
        end
    end

    assign w_div_last = r_period - 1'b1;
`else
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    assign w_div_last = DIV_LAST;
`endif

    assign w_enter_run  = (r_state != RUN) && start;
    assign w_hit        = (r_state == RUN) && r_barrier[MONSTER_COL] && !airborne;
    assign w_step       = (r_state == RUN) && (r_div == w_div_last);
    assign w_spawn      = w_lfsr[0] && (r_gap >= GAP_INIT);
    assign w_lfsr_en    = w_step && !w_hit;
    assign w_score_next = (r_barrier[DISP_W-1] && (r_score != 8'hFF)) ? r_score + 8'd1 : r_score;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (w_lfsr_en),
        .seed (LFSR_SEED),
        .q    (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_barrier   <= '0;
            r_score     <= '0;
            r_div       <= '0;
            r_gap       <= GAP_INIT;
            r_running   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                IDLE, OVER: begin
                    // The LFSR keeps its value across games so each game differs.
                    if (start) begin
                        r_state     <= RUN;
                        r_running   <= 1'b1;
                        r_game_over <= 1'b0;
                        r_barrier   <= '0;
                        r_score     <= '0;
                        r_div       <= '0;
                        r_gap       <= GAP_INIT;
                    end
                end
                RUN: begin
                    if (w_hit) begin
                        // A hit wins over a coincident step: the playfield freezes as-is.
                        r_state     <= OVER;
                        r_running   <= 1'b0;
                        r_game_over <= 1'b1;
                        r_div       <= '0;
                    end else if (w_step) begin
                        r_div     <= '0;
                        r_barrier <= {r_barrier[DISP_W-2:0], w_spawn};
                        r_gap     <= w_spawn ? 3'd0 : ((r_gap == 3'd7) ? 3'd7 : r_gap + 3'd1);
                        r_score   <= w_score_next;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_running   <= 1'b0;
                    r_game_over <= 1'b0;
                    r_div       <= '0;
                end
            endcase
        end
    end

    assign barrier   = r_barrier;
    assign running   = r_running;
    assign game_over = r_game_over;
    assign score     = r_score;
    // Decoded purely from registers, so no input reaches any output combinationally.
    assign step      = w_step;

endmodule

// File: tb/tb_barrier_sched.sv
// Randomized self-checking bench for barrier_sched against a queue-based game model.
// Define SPEEDUP_EN for both bench and RTL to check the speedup build.
module tb_barrier_sched;

    localparam int         STEP_DIV    = 4;
    localparam int         MIN_GAP     = 2;
    localparam int         MONSTER_COL = 6;
    localparam logic [7:0] SEED        = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       airborne = 1'b1;
    logic [7:0] barrier;
    logic       running;
    logic       game_over;
    logic [7:0] score;
    logic       step;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    barrier_sched #(
        .STEP_DIV    (STEP_DIV),
        .MIN_GAP     (MIN_GAP),
        .MONSTER_COL (MONSTER_COL),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .airborne  (airborne),
        .barrier   (barrier),
        .running   (running),
        .game_over (game_over),
        .score     (score),
        .step      (step)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural game model ----------------
    // Barriers are tracked as a list of column positions (steps since spawn).
    int         m_mode   = 0;          // 0 idle, 1 running, 2 over
    int         m_pos[$];
    int         m_gap    = MIN_GAP;
    int         m_score  = 0;
    int         m_cnt    = 0;          // cycles since entry or last step
    int         m_period = STEP_DIV;
    int         m_exits  = 0;
    logic [7:0] m_lfsr   = SEED;

    function automatic logic [7:0] m_pattern();
        logic [7:0] p;
        p = 8'h00;
        foreach (m_pos[i]) p[m_pos[i]] = 1'b1;
        return p;
    endfunction

    function automatic int m_period_for(input int s);
`ifdef SPEEDUP_EN
        int sh;
        int p;
        sh = s / 16;
        if (sh > 3) sh = 3;
        p = STEP_DIV / (1 << sh);
        return (p < 2) ? 2 : p;
`else
        return STEP_DIV + 0 * s;
`endif
    endfunction

    function automatic bit spacing_ok(input logic [7:0] b);
        int last;
        bit ok;
        last = -100;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                if (i - last < MIN_GAP + 1) ok = 1'b0;
                last = i;
            end
        end
        return ok;
    endfunction

    task automatic m_enter_run();
        m_mode = 1;
        m_pos.delete();
        m_score = 0;
        m_cnt = 0;
        m_gap = MIN_GAP;
        m_period = STEP_DIV;
    endtask

    task automatic m_do_step();
        int  keep[$];
        bit  spawn;
        spawn = m_lfsr[0] && (m_gap >= MIN_GAP);
        foreach (m_pos[i]) begin
            if (m_pos[i] == 7) begin
                m_exits++;
                if (m_score < 255) m_score++;
            end else begin
                keep.push_back(m_pos[i] + 1);
            end
        end
        m_pos = keep;
        if (spawn) m_pos.push_back(0);
        m_gap = spawn ? 0 : ((m_gap >= 7) ? 7 : m_gap + 1);
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_period = m_period_for(m_score);
    endtask

    always @(posedge clk) begin
        logic [7:0] pat;
        pat = m_pattern();
        if (rst) begin
            m_mode = 0;
            m_pos.delete();
            m_gap = MIN_GAP;
            m_score = 0;
            m_cnt = 0;
            m_period = STEP_DIV;
            m_lfsr = SEED;
        end else if (m_mode != 1) begin
            if (start) m_enter_run();
        end else if (pat[MONSTER_COL] && !airborne) begin
            m_mode = 2;
            m_cnt = 0;
        end else if (m_cnt == m_period - 1) begin
            m_do_step();
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        check("barrier",   barrier,   m_pattern());
        check("running",   running,   m_mode == 1);
        check("game_over", game_over, m_mode == 2);
        check("score",     score,     m_score);
        check("step",      step,      (m_mode == 1) && (m_cnt == m_period - 1));
        if (running && step) check("spacing", spacing_ok(barrier), 1);
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int         nsteps;
        int         cyc;
        int         base;
        bit         found;
        logic [7:0] held_b;
        logic [7:0] held_s;

        rst = 1'b1;
        start = 1'b0;
        airborne = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_barrier", barrier, 8'h00);
        check("rst_score",   score,   8'h00);
        check("rst_running", running, 1'b0);
        check("rst_over",    game_over, 1'b0);
        check("rst_step",    step,    1'b0);
        rst = 1'b0;

        // Idle with start low: nothing moves.
        nsteps = 0;
        repeat (50) begin
            @(negedge clk);
            if (step) nsteps++;
        end
        check("idle_steps",   nsteps,  0);
        check("idle_barrier", barrier, 8'h00);

        // First game from seed A5: spawn at step 1, then blocked by the gap.
        start = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) check("entry_running", running, 1'b1);
            if (c <= 16) check($sformatf("step_at_%0d", c), step, (c % 4) == 0);
            if (c == 5)  check("bar_step1", barrier, 8'h01);
            if (c == 9)  check("bar_step2", barrier, 8'h02);
            if (c == 13) check("bar_step3", barrier, 8'h04);
            if (c == 17) check("bar_step4", barrier, 8'h08);
        end

        // 500 more steps with the monster airborne.
        nsteps = 0;
        cyc = 0;
        while (nsteps < 500 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (step) nsteps++;
        end
        check("run500_steps", nsteps, 500);
        check("run500_alive", running, 1'b1);

        // Land exactly as a barrier at the monster column is about to scroll.
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (barrier[MONSTER_COL] && step) found = 1'b1;
        end
        check("coincide_found", found, 1'b1);
        held_b = barrier;
        held_s = score;
        airborne = 1'b0;
        @(negedge clk);
        check("hit_over",    game_over, 1'b1);
        check("hit_barrier", barrier, held_b);
        check("hit_score",   score,   held_s);
        for (int i = 0; i < 20; i++) begin
            airborne = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("frozen_barrier", barrier, held_b);
            check("frozen_score",   score,   held_s);
        end

        // Restart from OVER.
        airborne = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_running", running, 1'b1);
        check("restart_barrier", barrier, 8'h00);
        check("restart_score",   score,   8'h00);

        // Plain hit when a barrier first reaches the monster column.
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (barrier[MONSTER_COL]) found = 1'b1;
        end
        check("hit2_found", found, 1'b1);
        airborne = 1'b0;
        @(negedge clk);
        check("hit2_over", game_over, 1'b1);

        // Long game: score saturates once more than 300 barriers have left.
        airborne = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = m_exits;
        cyc = 0;
        while ((m_exits - base) <= 300 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("sat_exits_reached", (m_exits - base) > 300, 1'b1);
        check("sat_score", score, 8'hFF);

        // Random play: occasional landings and restarts.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 49) == 0);
            airborne = ($urandom_range(0, 9) != 0);
            @(negedge clk);
        end

        // Reset in the middle of a game.
        start = 1'b1;
        airborne = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_running", running, 1'b0);
        check("midrst_barrier", barrier, 8'h00);
        check("midrst_score",   score,   8'h00);
        check("midrst_step",    step,    1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
